// File: rtl/tk1_spi_pkg.sv
// ---------------------------------------------------------------------------
// tk1_spi_pkg
// Definitions shared by the tk1 SPI byte engine: the FSM state encoding and
// the number of bits moved per transfer.
// ---------------------------------------------------------------------------
package tk1_spi_pkg;

  // FSM encoding. IDLE must stay 0 so a cleared state register means idle.
  typedef enum logic [1:0] {
    SPI_IDLE = 2'd0,
    SPI_LOW  = 2'd1,
    SPI_HIGH = 2'd2
  } spi_state_t;

  localparam int BITS_PER_XFER = 8;

endpackage : tk1_spi_pkg

// File: rtl/tk1_spi_byte_engine.sv
// ---------------------------------------------------------------------------
// tk1_spi_byte_engine
// Byte-wide SPI mode-0 master (CPOL=0, CPHA=0, MSB first). Each accepted
// start strobe runs one 8-bit full-duplex transfer. The received byte is held
// on spi_rx_data until the next transfer begins shifting.
//
// Parameters
//   CLK_DIV         SCK half-period in clk cycles (1..256); one bit takes
//                   2*CLK_DIV cycles, a whole byte 16*CLK_DIV cycles.
//
// Ports
//   clk             system clock
//   reset           asynchronous, active-high reset
//   spi_ss          chip select, active low (inverse of the enable register)
//   spi_sck         serial clock, registered
//   spi_mosi        serial data out, registered
//   spi_miso        serial data in, sampled on the edge where SCK rises
//   spi_enable      new enable value, taken when spi_enable_we=1
//   spi_enable_we   enable write strobe; writing 0 mid-transfer aborts it
//   spi_start       single-cycle transfer request (idle and enabled only)
//   spi_tx_data     byte to send, taken when spi_tx_data_we=1 while idle
//   spi_tx_data_we  tx byte write strobe
//   spi_rx_data     last received byte
//   spi_ready       1 = idle, a start will be accepted
// ---------------------------------------------------------------------------
module tk1_spi_byte_engine
  import tk1_spi_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic       spi_ss,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  input  logic       spi_enable,
  input  logic       spi_enable_we,
  input  logic       spi_start,
  input  logic [7:0] spi_tx_data,
  input  logic       spi_tx_data_we,
  output logic [7:0] spi_rx_data,
  output logic       spi_ready
);

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [2:0] LAST_BIT   = 3'(BITS_PER_XFER - 1);

  spi_state_t state;
  logic       enable_reg;
  logic [7:0] tx_reg;
  logic [7:0] rx_reg;
  logic [2:0] bit_ctr;
  logic [7:0] div_ctr;
  logic       sck_reg;
  logic       mosi_reg;
  logic       ready_reg;

  logic       disable_wr;
  logic       abort;
  logic       start_ok;

  // A write of 0 to the enable register. While busy it kills the transfer;
  // while idle it also blocks a same-cycle start so no transfer ever runs
  // with chip select deasserted.
  assign disable_wr = spi_enable_we && !spi_enable;
  assign abort      = disable_wr && (state != SPI_IDLE);
  assign start_ok   = (state == SPI_IDLE) && enable_reg && spi_start && !disable_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SPI_IDLE;
      enable_reg <= 1'b0;
      tx_reg     <= 8'h00;
      rx_reg     <= 8'h00;
      bit_ctr    <= 3'd0;
      div_ctr    <= 8'd0;
      sck_reg    <= 1'b0;
      mosi_reg   <= 1'b0;
      ready_reg  <= 1'b1;
    end else begin
      if (spi_enable_we) begin
        enable_reg <= spi_enable;
      end

      if (abort) begin
        // rx_reg and tx_reg keep whatever partial shift they hold.
        state     <= SPI_IDLE;
        sck_reg   <= 1'b0;
        mosi_reg  <= 1'b0;
        ready_reg <= 1'b1;
      end else begin
        case (state)
          SPI_IDLE: begin
            sck_reg   <= 1'b0;
            mosi_reg  <= 1'b0;
            ready_reg <= 1'b1;
            if (start_ok) begin
              // Start wins over a same-cycle tx write: the old byte goes out.
              state     <= SPI_LOW;
              bit_ctr   <= 3'd0;
              div_ctr   <= DIV_RELOAD;
              ready_reg <= 1'b0;
              mosi_reg  <= tx_reg[7];
            end else if (spi_tx_data_we) begin
              tx_reg <= spi_tx_data;
            end
          end

          SPI_LOW: begin
            if (div_ctr == 8'd0) begin
              // MISO has been stable for the whole low phase; capture it on
              // the same edge that raises SCK.
              state   <= SPI_HIGH;
              sck_reg <= 1'b1;
              rx_reg  <= {rx_reg[6:0], spi_miso};
              div_ctr <= DIV_RELOAD;
            end else begin
              div_ctr <= div_ctr - 8'd1;
            end
          end

          SPI_HIGH: begin
            if (div_ctr == 8'd0) begin
              sck_reg <= 1'b0;
              tx_reg  <= {tx_reg[6:0], 1'b0};
              if (bit_ctr == LAST_BIT) begin
                state     <= SPI_IDLE;
                ready_reg <= 1'b1;
                mosi_reg  <= 1'b0;
              end else begin
                bit_ctr  <= bit_ctr + 3'd1;
                state    <= SPI_LOW;
                div_ctr  <= DIV_RELOAD;
                // Next bit is the new MSB after this shift.
                mosi_reg <= tx_reg[6];
              end
            end else begin
              div_ctr <= div_ctr - 8'd1;
            end
          end

          default: begin
            state     <= SPI_IDLE;
            sck_reg   <= 1'b0;
            mosi_reg  <= 1'b0;
            ready_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign spi_ss      = !enable_reg;
  assign spi_sck     = sck_reg;
  assign spi_mosi    = mosi_reg;
  assign spi_rx_data = rx_reg;
  assign spi_ready   = ready_reg;

endmodule : tk1_spi_byte_engine

// File: tb/tb_tk1_spi_byte_engine.sv
// ---------------------------------------------------------------------------
// tb_tk1_spi_byte_engine
// Two engines (CLK_DIV=1 and CLK_DIV=4) each talk to a behavioural SPI slave.
// Stimulus pushes the expected outcome of every transfer into a per-engine
// queue; a monitor pops an entry whenever an engine returns to ready.
// ---------------------------------------------------------------------------
module tb_tk1_spi_byte_engine;

  localparam int NI     = 2;
  localparam int BUDGET = 3000;

  typedef enum int {K_FULL, K_ABORT, K_RESET} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst      [NI];
  logic       ss       [NI];
  logic       sck      [NI];
  logic       mosi     [NI];
  logic       miso     [NI];
  logic       en       [NI];
  logic       en_we    [NI];
  logic       start    [NI];
  logic [7:0] tx_data  [NI];
  logic       tx_we    [NI];
  logic [7:0] rx_data  [NI];
  logic       ready    [NI];

  int checks   = 0;
  int failures = 0;

  exp_t       sb_q       [NI][$];
  logic [7:0] slave_byte [NI];
  int         slv_rises  [NI];
  logic [7:0] slv_mosi   [NI];

  // Reference model of the programmer-visible registers.
  logic       m_en [NI];
  logic [7:0] m_tx [NI];
  logic [7:0] m_rx [NI];

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, i, act, exp);
    end
  endtask

  task automatic finish_xfer(input int i, input int cyc, input bit ss_bad, input bit per_bad);
    exp_t e;
    if (sb_q[i].size() == 0) return;
    e = sb_q[i].pop_front();
    $display("xfer dut%0d kind=%s tx=%02h slave=%02h rx=%02h mosi=%02h cycles=%0d rises=%0d",
             i, e.kind.name(), e.tx, slave_byte[i], rx_data[i], slv_mosi[i], cyc, slv_rises[i]);
    case (e.kind)
      K_FULL: begin
        check("rx_data", i, 32'(rx_data[i]), 32'(e.rx));
        check("mosi_byte", i, 32'(slv_mosi[i]), 32'(e.tx));
        check("busy_cycles", i, 32'(cyc), 32'(16 * div_of(i)));
        check("sck_rises", i, 32'(slv_rises[i]), 32'd8);
        check("ss_low_busy", i, 32'(ss_bad), 32'd0);
        check("sck_half_period", i, 32'(per_bad), 32'd0);
        check("idle_sck", i, 32'(sck[i]), 32'd0);
        check("idle_mosi", i, 32'(mosi[i]), 32'd0);
      end
      K_ABORT: begin
        check("abort_rx_partial", i, 32'(rx_data[i]), 32'(e.rx));
        check("abort_rises", i, 32'(slv_rises[i]), 32'd3);
        check("abort_mosi_bits", i, 32'(slv_mosi[i][2:0]), 32'(e.tx[7:5]));
        check("abort_ss", i, 32'(ss[i]), 32'd1);
        check("abort_sck", i, 32'(sck[i]), 32'd0);
      end
      default: begin
        check("reset_rx", i, 32'(rx_data[i]), 32'd0);
        check("reset_ss", i, 32'(ss[i]), 32'd1);
        check("reset_sck", i, 32'(sck[i]), 32'd0);
      end
    endcase
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int D = (gi == 0) ? 1 : 4;

    tk1_spi_byte_engine #(.CLK_DIV(D)) u_dut (
      .clk            (clk),
      .reset          (rst[gi]),
      .spi_ss         (ss[gi]),
      .spi_sck        (sck[gi]),
      .spi_mosi       (mosi[gi]),
      .spi_miso       (miso[gi]),
      .spi_enable     (en[gi]),
      .spi_enable_we  (en_we[gi]),
      .spi_start      (start[gi]),
      .spi_tx_data    (tx_data[gi]),
      .spi_tx_data_we (tx_we[gi]),
      .spi_rx_data    (rx_data[gi]),
      .spi_ready      (ready[gi])
    );

    // Mode-0 slave: capture MOSI on each rising SCK, then present next bit.
    always @(posedge sck[gi]) begin
      #1;
      slv_mosi[gi]  = {slv_mosi[gi][6:0], mosi[gi]};
      slv_rises[gi] = slv_rises[gi] + 1;
      if (slv_rises[gi] < 8) miso[gi] = slave_byte[gi][3'(7 - slv_rises[gi])];
      else                   miso[gi] = 1'b0;
    end

    logic prev_ready = 1'b1;
    logic prev_sck   = 1'b0;
    int   busy_cyc   = 0;
    int   lo_run     = 0;
    int   hi_run     = 0;
    bit   ss_bad     = 1'b0;
    bit   per_bad    = 1'b0;

    always @(posedge clk) begin
      #1;
      if (ready[gi] === 1'b0) begin
        if (prev_ready === 1'b1) begin
          busy_cyc = 0; lo_run = 0; hi_run = 0; ss_bad = 1'b0; per_bad = 1'b0;
          check("xfer_expected", gi, 32'(sb_q[gi].size() != 0), 32'd1);
        end
        busy_cyc++;
        if (ss[gi] !== 1'b0) ss_bad = 1'b1;
        if (sck[gi] === 1'b1) begin
          if (prev_sck !== 1'b1) begin
            if (lo_run != D) per_bad = 1'b1;
            hi_run = 0;
          end
          hi_run++;
        end else begin
          if (prev_sck === 1'b1) begin
            if (hi_run != D) per_bad = 1'b1;
            lo_run = 0;
          end
          lo_run++;
        end
      end else if (prev_ready === 1'b0) begin
        if (prev_sck === 1'b1 && hi_run != D) per_bad = 1'b1;
        finish_xfer(gi, busy_cyc, ss_bad, per_bad);
      end
      prev_ready = ready[gi];
      prev_sck   = sck[gi];
    end
  end

  task automatic pulse_enable(input int i, input logic v);
    @(negedge clk);
    en_we[i] = 1'b1; en[i] = v;
    @(negedge clk);
    en_we[i] = 1'b0;
    m_en[i]  = v;
  endtask

  // Only called while the engine is idle.
  task automatic write_tx(input int i, input logic [7:0] d);
    @(negedge clk);
    tx_we[i] = 1'b1; tx_data[i] = d;
    @(negedge clk);
    tx_we[i] = 1'b0;
    m_tx[i]  = d;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (ready[i] !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", i, 32'(ready[i]), 32'd1);
  endtask

  task automatic wait_rises(input int i, input int k);
    int n;
    n = 0;
    while (slv_rises[i] < k && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("rises_within_budget", i, 32'(slv_rises[i] >= k), 32'd1);
  endtask

  // Issue a start (optionally with a same-cycle tx write) from idle.
  task automatic launch(input int i, input logic [7:0] slv, input bit also_tx,
                        input logic [7:0] td, input kind_t kind);
    exp_t e;
    @(negedge clk);
    slave_byte[i] = slv;
    slv_rises[i]  = 0;
    slv_mosi[i]   = 8'h00;
    miso[i]       = slv[7];
    start[i]      = 1'b1;
    if (also_tx) begin
      tx_we[i] = 1'b1; tx_data[i] = td;
    end
    if (m_en[i]) begin
      e.kind = kind;
      e.tx   = m_tx[i];
      case (kind)
        K_FULL:  begin e.rx = slv;                         m_tx[i] = 8'h00; end
        K_ABORT: begin e.rx = {m_rx[i][4:0], slv[7:5]};    m_tx[i] = {m_tx[i][5:0], 2'b00}; end
        default: begin e.rx = 8'h00;                       m_tx[i] = 8'h00; end
      endcase
      m_rx[i] = e.rx;
      sb_q[i].push_back(e);
    end else if (also_tx) begin
      m_tx[i] = td;
    end
    @(negedge clk);
    start[i] = 1'b0;
    tx_we[i] = 1'b0;
  endtask

  task automatic junk_while_busy(input int i, input logic [7:0] d);
    @(negedge clk);
    if (ready[i] === 1'b0) begin
      start[i] = 1'b1; tx_we[i] = 1'b1; tx_data[i] = d;
      @(negedge clk);
      start[i] = 1'b0; tx_we[i] = 1'b0;
    end
  endtask

  task automatic run_engine(input int i);
    // Basic transfer.
    pulse_enable(i, 1'b1);
    write_tx(i, 8'hA5);
    launch(i, 8'h3C, 1'b0, 8'h00, K_FULL);
    wait_idle(i);

    // All-ones byte.
    write_tx(i, 8'hFF);
    launch(i, 8'($urandom), 1'b0, 8'h00, K_FULL);
    wait_idle(i);

    // Start while disabled does nothing.
    pulse_enable(i, 1'b0);
    launch(i, 8'h5A, 1'b0, 8'h00, K_FULL);
    repeat (20) @(negedge clk);
    check("disabled_no_sck", i, 32'(slv_rises[i]), 32'd0);
    check("disabled_ready", i, 32'(ready[i]), 32'd1);
    check("disabled_ss", i, 32'(ss[i]), 32'd1);

    // Start and tx write while busy are ignored; tx_reg ends shifted out.
    pulse_enable(i, 1'b1);
    write_tx(i, 8'h80);
    launch(i, 8'($urandom), 1'b0, 8'h00, K_FULL);
    repeat (3) @(negedge clk);
    junk_while_busy(i, 8'h11);
    wait_idle(i);
    launch(i, 8'($urandom), 1'b0, 8'h00, K_FULL);
    wait_idle(i);

    // Abort after the third SCK rise.
    write_tx(i, 8'hF0);
    launch(i, 8'($urandom), 1'b0, 8'h00, K_ABORT);
    wait_rises(i, 3);
    en_we[i] = 1'b1; en[i] = 1'b0;
    @(negedge clk);
    en_we[i] = 1'b0;
    m_en[i]  = 1'b0;
    check("abort_ready_next", i, 32'(ready[i]), 32'd1);
    check("abort_ss_next", i, 32'(ss[i]), 32'd1);
    pulse_enable(i, 1'b1);
    write_tx(i, 8'h0F);
    launch(i, 8'($urandom), 1'b0, 8'h00, K_FULL);
    wait_idle(i);

    // Same-cycle tx write and start: old byte goes out, write dropped.
    write_tx(i, 8'hC3);
    launch(i, 8'($urandom), 1'b1, 8'h55, K_FULL);
    wait_idle(i);
    launch(i, 8'($urandom), 1'b0, 8'h00, K_FULL);
    wait_idle(i);

    // Randomized traffic.
    repeat (10) begin
      if ($urandom_range(0, 3) != 0) write_tx(i, 8'($urandom));
      launch(i, 8'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom), K_FULL);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 8)) @(negedge clk);
        junk_while_busy(i, 8'($urandom));
      end
      wait_idle(i);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a transfer.
    write_tx(i, 8'hFF);
    launch(i, 8'($urandom), 1'b0, 8'h00, K_RESET);
    wait_rises(i, 2);
    #2;
    rst[i] = 1'b1;
    #1;
    check("async_rst_ss", i, 32'(ss[i]), 32'd1);
    check("async_rst_sck", i, 32'(sck[i]), 32'd0);
    check("async_rst_mosi", i, 32'(mosi[i]), 32'd0);
    check("async_rst_ready", i, 32'(ready[i]), 32'd1);
    check("async_rst_rx", i, 32'(rx_data[i]), 32'd0);
    m_en[i] = 1'b0; m_tx[i] = 8'h00; m_rx[i] = 8'h00;
    repeat (2) @(negedge clk);
    rst[i] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; miso[i] = 1'b0; en[i] = 1'b0; en_we[i] = 1'b0;
      start[i] = 1'b0; tx_data[i] = 8'h00; tx_we[i] = 1'b0;
      slave_byte[i] = 8'h00; slv_rises[i] = 0; slv_mosi[i] = 8'h00;
      m_en[i] = 1'b0; m_tx[i] = 8'h00; m_rx[i] = 8'h00;
    end
    #1;
    // Reset values appear before any clock edge.
    for (int i = 0; i < NI; i++) begin
      check("reset_ss", i, 32'(ss[i]), 32'd1);
      check("reset_sck", i, 32'(sck[i]), 32'd0);
      check("reset_mosi", i, 32'(mosi[i]), 32'd0);
      check("reset_ready", i, 32'(ready[i]), 32'd1);
      check("reset_rx", i, 32'(rx_data[i]), 32'd0);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NI; i++) run_engine(i);

    repeat (5) @(negedge clk);
    for (int i = 0; i < NI; i++) check("scoreboard_drained", i, 32'(sb_q[i].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_tk1_spi_byte_engine
